systolic2x2_feeder: RTL and testbench
=====================================

Name: systolic2x2_feeder

Overview:
Operand staging and skew engine that drives the left and top edges of the 2x2 systolic array (`systolic2x2`).
- Host writes a 2x2 input matrix A and a 2x2 weight matrix B through a simple write port.
- On `start`, the block emits the diagonally skewed edge streams the array consumes, pulses `clear_acc` on the first beat, waits out the array drain latency, then pulses `done`.
- It is the producer end of the array's operand interface.

Parameters:
- DW, 16, operand width of every matrix element and edge output.
- DRAIN_CYCLES, 3, cycles spent in DRAIN after the last feed beat before `done`; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the matrix registers.
- wr_sel  in  1  0 = A (inputs), 1 = B (weights).
- wr_addr  in  2  element index = row*2+col.
- wr_data  in  DW  element value.
- start  in  1  single-cycle request to run one job.
- a_row0  out  DW  left edge feed, array row 0.
- a_row1  out  DW  left edge feed, array row 1.
- b_col0  out  DW  top edge feed, array column 0.
- b_col1  out  DW  top edge feed, array column 1.
- feed_valid  out  1  high during the 3 STREAM beats.
- clear_acc  out  1  high on STREAM beat 0 only.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- job_count  out  16  completed-job counter (optional feature).

Behaviour:
- Reset (sync, rst=1 at an edge):
  - all 8 matrix registers := 0; state := IDLE; step := 0; job_count := 0.
  - all outputs read 0 in the following cycle.
  - Reset mid-job aborts without a `done` pulse.
- States: IDLE -> STREAM (3 beats, step 0..2) -> DRAIN (DRAIN_CYCLES beats) -> DONE (1 beat) -> IDLE.
- Start acceptance: `start` sampled high in IDLE moves the block to STREAM with step=0. `start` in any other state is ignored; no queuing.
- Writes: accepted only in IDLE; ignored when busy. A write in the same cycle as an accepted `start` is committed at that edge, so the job uses the new value.
- Edge outputs are a combinational decode of state, step and the matrix registers; they are 0 outside STREAM. Beat t in STREAM:
  - a_row0 = A[0][t] for t<2, else 0.
  - a_row1 = A[1][t-1] for t>=1, else 0.
  - b_col0 = B[t][0] for t<2, else 0.
  - b_col1 = B[t-1][1] for t>=1, else 0.
- `feed_valid` = (state==STREAM); `clear_acc` = (state==STREAM && step==0); `busy` = (state!=IDLE); `done` = (state==DONE).
- Latency: `start` accepted at edge E0; first feed beat in the cycle after E0; `done` high exactly 3+DRAIN_CYCLES cycles after the first beat.
- Back-to-back jobs: `start` asserted during the DONE cycle is ignored; it is accepted on the next IDLE cycle. Minimum job period is 5+DRAIN_CYCLES cycles.
- The DRAIN counter width is 4 bits; DRAIN_CYCLES=0 is illegal and must be rejected by an elaboration-time check.

Optional Feature:
- Macro: SYSTOLIC2X2_FEEDER_JOBCNT_EN.
- Defined: job_count increments by 1 on every DONE cycle and saturates at 16'hFFFF; it resets to 0.
- Undefined: job_count is tied to 16'h0000 and no counter flops are instantiated.

Decomposition:
- Shared package systolic_pkg holds:
  - N=2 and the default DW=16.
  - feeder state encoding: IDLE=2'd0, STREAM=2'd1, DRAIN=2'd2, DONE=2'd3.
  - STREAM_BEATS=3 (2N-1).
  - matrix index helpers.
- No sub-module: the skew is a pure decode of step, so a single module is sufficient.

Test Plan:
- Load stream: write A={{10,20},{5,10}}, B={{1,2},{3,4}}, then pulse start. Expect:
  - beat0: a_row0=10, a_row1=0, b_col0=1, b_col1=0, clear_acc=1.
  - beat1: a_row0=20, a_row1=5, b_col0=3, b_col1=2, clear_acc=0.
  - beat2: a_row0=0, a_row1=10, b_col0=0, b_col1=4.
- Timing: same job with DRAIN_CYCLES=3 -> feed_valid high for exactly 3 cycles; done pulses exactly 6 cycles after beat0; busy drops the cycle after done.
- Write-while-busy: in STREAM beat1, write A[0][0]=99 -> ignored. A second job without rewriting shows a_row0=10 on beat0.
- Start ignored / simultaneous: pulse start during DRAIN -> no second job. In IDLE, write B[0][0]=7 with start in the same cycle -> beat0 b_col0=7.
- Reset mid-job: assert rst during STREAM beat1 -> next cycle all outputs 0, busy=0, no done pulse. A subsequent start streams all-zero operands.
- Job counter: with SYSTOLIC2X2_FEEDER_JOBCNT_EN, 3 jobs -> job_count=3, and rst returns it to 0. Without the macro, job_count stays 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic array and its operand feeder.
// Holds array geometry, feeder state encoding and matrix index helpers.
package systolic_pkg;

  localparam int N            = 2;
  localparam int DW_DEF       = 16;
  localparam int STREAM_BEATS = 2 * N - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } fstate_t;

  // element index = row*2+col
  function automatic logic [1:0] midx(
    input logic r,
    input logic c
  );
    return {r, c};
  endfunction

endpackage

// File: rtl/systolic2x2_feeder.sv
// Stages 2x2 A/B operands and emits the skewed edge streams for systolic2x2.
// Define SYSTOLIC2X2_FEEDER_JOBCNT_EN to enable the saturating job counter.
module systolic2x2_feeder
  import systolic_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [1:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic [DW-1:0] a_row0,
  output logic [DW-1:0] a_row1,
  output logic [DW-1:0] b_col0,
  output logic [DW-1:0] b_col1,
  output logic          feed_valid,
  output logic          clear_acc,
  output logic          busy,
  output logic          done,
  output logic [15:0]   job_count
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
    $error("DRAIN_CYCLES must be in 1..15");
  end

  localparam logic [1:0] LAST_BEAT = 2'(STREAM_BEATS - 1);
  localparam logic [3:0] LAST_DRN  = 4'(DRAIN_CYCLES - 1);

  logic [DW-1:0] ma [4];
  logic [DW-1:0] mb [4];

  fstate_t    st, st_n;
  logic [1:0] step, step_n;
  logic [3:0] dcnt, dcnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      step <= '0;
      dcnt <= '0;
      for (int i = 0; i < 4; i++) begin
        ma[i] <= '0;
        mb[i] <= '0;
      end
    end else begin
      st   <= st_n;
      step <= step_n;
      dcnt <= dcnt_n;
      if (wr_en && st == IDLE) begin
        if (wr_sel) mb[wr_addr] <= wr_data;
        else        ma[wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    st_n   = st;
    step_n = step;
    dcnt_n = dcnt;
    unique case (st)
      IDLE: begin
        if (start) begin
          st_n   = STREAM;
          step_n = '0;
        end
      end
      STREAM: begin
        if (step == LAST_BEAT) begin
          st_n   = DRAIN;
          dcnt_n = '0;
        end else begin
          step_n = step + 2'd1;
        end
      end
      DRAIN: begin
        if (dcnt == LAST_DRN) st_n = DONE;
        else                  dcnt_n = dcnt + 4'd1;
      end
      DONE: begin
        st_n   = IDLE;
        step_n = '0;
      end
      default: st_n = IDLE;
    endcase
  end

  // diagonal skew: row/col r lags by r beats
  always_comb begin
    a_row0 = '0;
    a_row1 = '0;
    b_col0 = '0;
    b_col1 = '0;
    if (st == STREAM) begin
      unique case (1'b1)
        (step == 2'd0): begin
          a_row0 = ma[midx(1'b0, 1'b0)];
          b_col0 = mb[midx(1'b0, 1'b0)];
        end
        (step == 2'd1): begin
          a_row0 = ma[midx(1'b0, 1'b1)];
          a_row1 = ma[midx(1'b1, 1'b0)];
          b_col0 = mb[midx(1'b1, 1'b0)];
          b_col1 = mb[midx(1'b0, 1'b1)];
        end
        (step == 2'd2): begin
          a_row1 = ma[midx(1'b1, 1'b1)];
          b_col1 = mb[midx(1'b1, 1'b1)];
        end
        default: ;
      endcase
    end
  end

  assign feed_valid = (st == STREAM);
  assign clear_acc  = (st == STREAM) && (step == 2'd0);
  assign busy       = (st != IDLE);
  assign done       = (st == DONE);

`ifdef SYSTOLIC2X2_FEEDER_JOBCNT_EN
  logic [15:0] jc;

  always_ff @(posedge clk) begin
    if (rst)                              jc <= '0;
    else if (st == DONE && jc != 16'hFFFF) jc <= jc + 16'd1;
  end

  assign job_count = jc;
`else
  assign job_count = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic2x2_feeder.sv
// Self-checking bench for systolic2x2_feeder against a matrix-level model.
// Covers skew, timing, write/start gating, reset abort and the job counter.
module tb_systolic2x2_feeder;

  localparam int DW    = 16;
  localparam int DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          wr_sel;
  logic [1:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [DW-1:0] a_row0, a_row1, b_col0, b_col1;
  logic          feed_valid, clear_acc, busy, done;
  logic [15:0]   job_count;

  systolic2x2_feeder #(.DW(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start),
    .a_row0(a_row0), .a_row1(a_row1),
    .b_col0(b_col0), .b_col1(b_col1),
    .feed_valid(feed_valid), .clear_acc(clear_acc),
    .busy(busy), .done(done),
    .job_count(job_count)
  );

  always #5 clk = ~clk;

  // reference matrices A[row][col], B[row][col]
  int unsigned ra [2][2];
  int unsigned rb [2][2];
  int unsigned exp_jobs;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint exp_jc();
`ifdef SYSTOLIC2X2_FEEDER_JOBCNT_EN
    return longint'(exp_jobs);
`else
    return 0;
`endif
  endfunction

  // edge k carries element k of its row/col, delayed by k beats
  function automatic int unsigned edge_a(int r, int t);
    int c = t - r;
    return (c >= 0 && c < 2) ? ra[r][c] : 0;
  endfunction

  function automatic int unsigned edge_b(int c, int t);
    int r = t - c;
    return (r >= 0 && r < 2) ? rb[r][c] : 0;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        ra[r][c] = 0;
        rb[r][c] = 0;
      end
  endtask

  task automatic write(input bit sel, input int r, input int c,
                       input int unsigned v);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 2'(r * 2 + c);
    wr_data = DW'(v);
    tick();
    wr_en   = 1'b0;
    if (sel) rb[r][c] = v;
    else     ra[r][c] = v;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".valid"}, feed_valid, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".a0"}, a_row0, 0);
    chk({tag, ".b1"}, b_col1, 0);
  endtask

  // mode bits: 0 write A00 at beat1, 1 start in drain, 2 start in done
  task automatic run_job(input string tag, input int mode);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk({tag, ".a_row0"}, a_row0, edge_a(0, t));
      chk({tag, ".a_row1"}, a_row1, edge_a(1, t));
      chk({tag, ".b_col0"}, b_col0, edge_b(0, t));
      chk({tag, ".b_col1"}, b_col1, edge_b(1, t));
      chk({tag, ".feed_valid"}, feed_valid, 1);
      chk({tag, ".clear_acc"}, clear_acc, t == 0);
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".done_early"}, done, 0);
      if (t == 1 && mode[0]) begin
        wr_en = 1'b1; wr_sel = 1'b0;
        wr_addr = 2'd0; wr_data = 16'd99;
      end
      tick();
      wr_en = 1'b0;
    end
    for (int d = 0; d < DRAIN; d++) begin
      chk({tag, ".drain_valid"}, feed_valid, 0);
      chk({tag, ".drain_busy"}, busy, 1);
      chk({tag, ".drain_done"}, done, 0);
      chk({tag, ".drain_a0"}, a_row0, 0);
      if (d == 0 && mode[1]) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".done_busy"}, busy, 1);
    if (mode[2]) start = 1'b1;
    tick();
    start = 1'b0;
    if (exp_jobs != 32'hFFFF) exp_jobs++;
    chk({tag, ".post_busy"}, busy, 0);
    chk({tag, ".post_done"}, done, 0);
    chk({tag, ".job_count"}, job_count, exp_jc());
    tick();
    chk({tag, ".no_rerun"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0;
    wr_addr = '0; wr_data = '0; start = 1'b0;
    clear_model();
    exp_jobs = 0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset.jc", job_count, 0);

    write(0, 0, 0, 10); write(0, 0, 1, 20);
    write(0, 1, 0, 5);  write(0, 1, 1, 10);
    write(1, 0, 0, 1);  write(1, 0, 1, 2);
    write(1, 1, 0, 3);  write(1, 1, 1, 4);
    chk("idle.a0", a_row0, 0);
    run_job("load", 0);

    run_job("wr_busy", 1);
    run_job("rerun", 0);
    chk("rerun.a00_kept", ra[0][0], 10);

    run_job("start_drain", 2);
    run_job("start_done", 4);
    // start accepted on the IDLE cycle after DONE (period 5+DRAIN)
    run_job("after_done", 0);

    // write and start on the same edge: job sees the new B00
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 2'd0; wr_data = 16'd7;
    rb[0][0] = 7;
    run_job("wr_start", 0);

    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          write(0, r, c, $urandom_range(0, 16'hFFFF));
          write(1, r, c, $urandom_range(0, 16'hFFFF));
        end
      run_job("rand", 0);
    end
    chk("jobs.total", job_count, exp_jc());

    // reset during STREAM beat1
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort.beat1", feed_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    exp_jobs = 0;
    chk_idle("abort");
    chk("abort.a1", a_row1, 0);
    chk("abort.b0", b_col0, 0);
    chk("abort.jc", job_count, 0);
    for (int i = 0; i < DRAIN + 4; i++) begin
      chk("abort.no_done", done, 0);
      tick();
    end
    run_job("zero", 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
